// File: rtl/param_fifo.sv
// param_fifo: synchronous FIFO with registered read data, per-edge status pulses and level flags.
module param_fifo #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 3,
  parameter int AF_LEVEL = (1 << ADDR_W) - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              wr_ack,
  output logic              wr_err,
  output logic              rd_ack,
  output logic              rd_err,
  output logic [ADDR_W:0]   data_count,
  output logic [2:0]        state
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_AF   = (ADDR_W + 1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] CNT_AE   = (ADDR_W + 1)'(AE_LEVEL);

  if (DATA_W < 1 || ADDR_W < 1) begin : g_bad_width
    $error("param_fifo: DATA_W and ADDR_W must be at least 1");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("param_fifo: AF_LEVEL must lie in 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("param_fifo: AE_LEVEL must lie in 0..DEPTH-1");
  end

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    WRITE    = 3'b001,
    READ     = 3'b010,
    WR_ERROR = 3'b011,
    RD_ERROR = 3'b100,
    WR_RD    = 3'b101
  } state_t;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_dout;
  logic [ADDR_W-1:0] r_head;
  logic [ADDR_W-1:0] r_tail;
  logic [ADDR_W:0]   r_count;
  logic              r_wr_ack;
  logic              r_wr_err;
  logic              r_rd_ack;
  logic              r_rd_err;
  state_t            r_state;
  state_t            w_next;
  logic              w_do_wr;
  logic              w_do_rd;
  logic [ADDR_W:0]   w_next_count;

  assign full         = (r_count == CNT_FULL);
  assign empty        = (r_count == '0);
  assign almost_full  = (r_count >= CNT_AF);
  assign almost_empty = (r_count <= CNT_AE);
  assign dout         = r_dout;
  assign data_count   = r_count;
  assign wr_ack       = r_wr_ack;
  assign wr_err       = r_wr_err;
  assign rd_ack       = r_rd_ack;
  assign rd_err       = r_rd_err;
  assign state        = r_state;

  // A full FIFO still accepts a write when a read frees the head slot at the same edge.
  always_comb begin
    w_do_wr      = wr_en && (!full || rd_en);
    w_do_rd      = rd_en && !empty;
    w_next_count = r_count + (ADDR_W + 1)'(w_do_wr) - (ADDR_W + 1)'(w_do_rd);
    w_next       = (wr_en && rd_en) ? (empty ? WRITE : WR_RD)
                 : wr_en            ? (full ? WR_ERROR : WRITE)
                 : rd_en            ? (empty ? RD_ERROR : READ)
                 :                    IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_dout   <= '0;
      r_wr_ack <= 1'b0;
      r_wr_err <= 1'b0;
      r_rd_ack <= 1'b0;
      r_rd_err <= 1'b0;
      r_state  <= IDLE;
    end else begin
      r_head   <= r_head + ADDR_W'(w_do_rd);
      r_tail   <= r_tail + ADDR_W'(w_do_wr);
      r_count  <= w_next_count;
      r_dout   <= w_do_rd ? r_mem[r_head] : r_dout;
      r_wr_ack <= w_do_wr;
      r_wr_err <= wr_en && !w_do_wr;
      r_rd_ack <= w_do_rd;
      r_rd_err <= rd_en && !w_do_rd;
      r_state  <= w_next;
    end
  end

  // Storage is deliberately not reset; stale words become unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (!reset && w_do_wr) r_mem[r_tail] <= din;
  end
endmodule

// File: tb/tb_param_fifo.sv
// tb_param_fifo: directed checks of param_fifo at DATA_W=32, ADDR_W=3, AF_LEVEL=7, AE_LEVEL=1.
module tb_param_fifo;
  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] din;
  logic [31:0] dout;
  logic        full, empty, almost_full, almost_empty;
  logic        wr_ack, wr_err, rd_ack, rd_err;
  logic [3:0]  data_count;
  logic [2:0]  state;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] q [$];
  logic [31:0] exp_d;

  param_fifo #(.DATA_W(32), .ADDR_W(3), .AF_LEVEL(7), .AE_LEVEL(1)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .din(din),
    .dout(dout), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .wr_ack(wr_ack), .wr_err(wr_err),
    .rd_ack(rd_ack), .rd_err(rd_err), .data_count(data_count), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled one falling edge later.
  task automatic cyc(input logic w, input logic r, input logic [31:0] d);
    wr_en = w;
    rd_en = r;
    din   = d;
    @(negedge clk);
  endtask

  task automatic status(input string tag, input logic [2:0] st, input logic wa, input logic we,
                        input logic ra, input logic re, input logic [3:0] cnt);
    check({tag, " state"}, state, st);
    check({tag, " wr_ack"}, wr_ack, wa);
    check({tag, " wr_err"}, wr_err, we);
    check({tag, " rd_ack"}, rd_ack, ra);
    check({tag, " rd_err"}, rd_err, re);
    check({tag, " count"}, data_count, cnt);
  endtask

  initial begin
    reset = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;
    @(negedge clk);
    cyc(1'b0, 1'b0, 32'h0);
    reset = 1'b0;
    status("reset", 3'b000, 0, 0, 0, 0, 4'd0);
    check("reset dout", dout, 32'h0);
    check("reset empty", empty, 1'b1);
    check("reset almost_empty", almost_empty, 1'b1);
    check("reset full", full, 1'b0);
    check("reset almost_full", almost_full, 1'b0);

    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 1'b0, 32'h10 + 32'(i));
      status($sformatf("fill%0d", i), 3'b001, 1, 0, 0, 0, 4'(i));
      check($sformatf("fill%0d almost_full", i), almost_full, i >= 7);
      check($sformatf("fill%0d full", i), full, i == 8);
      check($sformatf("fill%0d almost_empty", i), almost_empty, i <= 1);
    end
    cyc(1'b1, 1'b0, 32'h19);
    status("overflow", 3'b011, 0, 1, 0, 0, 4'd8);
    check("overflow full", full, 1'b1);

    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 1'b1, 32'h0);
      status($sformatf("drain%0d", i), 3'b010, 0, 0, 1, 0, 4'(8 - i));
      check($sformatf("drain%0d dout", i), dout, 32'h10 + 32'(i));
      check($sformatf("drain%0d empty", i), empty, i == 8);
      check($sformatf("drain%0d almost_empty", i), almost_empty, (8 - i) <= 1);
    end
    cyc(1'b0, 1'b1, 32'h0);
    status("underflow", 3'b100, 0, 0, 0, 1, 4'd0);
    check("underflow dout", dout, 32'h18);
    cyc(1'b0, 1'b0, 32'h0);
    status("idle pulses clear", 3'b000, 0, 0, 0, 0, 4'd0);

    cyc(1'b1, 1'b1, 32'hA0);
    status("wrrd empty", 3'b001, 1, 0, 0, 1, 4'd1);
    check("wrrd empty dout", dout, 32'h18);
    for (int i = 1; i <= 7; i++) cyc(1'b1, 1'b0, 32'hA0 + 32'(i));
    check("refill full", full, 1'b1);
    cyc(1'b1, 1'b1, 32'hB0);
    status("wrrd full", 3'b101, 1, 0, 1, 0, 4'd8);
    check("wrrd full dout", dout, 32'hA0);
    for (int i = 1; i <= 8; i++) begin
      exp_d = (i == 8) ? 32'hB0 : 32'hA0 + 32'(i);
      cyc(1'b0, 1'b1, 32'h0);
      check($sformatf("post-full drain%0d", i), dout, exp_d);
    end
    check("post-full empty", empty, 1'b1);

    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b0, 32'hC00 + 32'(i));
      cyc(1'b0, 1'b1, 32'h0);
      check($sformatf("pair%0d dout", i), dout, 32'hC00 + 32'(i));
    end
    for (int i = 0; i < 4; i++) begin
      q.push_back(32'hD00 + 32'(i));
      cyc(1'b1, 1'b0, 32'hD00 + 32'(i));
    end
    for (int i = 4; i < 16; i++) begin
      q.push_back(32'hD00 + 32'(i));
      cyc(1'b1, 1'b1, 32'hD00 + 32'(i));
      exp_d = q.pop_front();
      check($sformatf("conc%0d dout", i), dout, exp_d);
      check($sformatf("conc%0d count", i), data_count, 4'd4);
      check($sformatf("conc%0d state", i), state, 3'b101);
    end

    cyc(1'b1, 1'b0, 32'hE0);
    check("pre-reset count", data_count, 4'd5);
    reset = 1'b1;
    cyc(1'b1, 1'b0, 32'hE1);
    reset = 1'b0;
    status("midreset", 3'b000, 0, 0, 0, 0, 4'd0);
    check("midreset empty", empty, 1'b1);
    cyc(1'b0, 1'b1, 32'h0);
    status("post-reset read", 3'b100, 0, 0, 0, 1, 4'd0);
    check("post-reset dout", dout, 32'h0);
    cyc(1'b1, 1'b0, 32'h55);
    cyc(1'b0, 1'b1, 32'h0);
    check("post-reset fifo dout", dout, 32'h55);
    cyc(1'b0, 1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameter DATA_W, default 32, data word width in bits; legal range 1 or more.
REQ-002 Parameter ADDR_W, default 3, pointer width; DEPTH = 2**ADDR_W entries; legal range 1 or more.
REQ-003 Parameter AF_LEVEL, default DEPTH-1, almost-full threshold; legal range 1..DEPTH.
REQ-004 Parameter AE_LEVEL, default 1, almost-empty threshold; legal range 0..DEPTH-1.
REQ-005 One clock and one reset: reset is synchronous and active-high.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 wr_en  input  1  write request, sampled at rising edge.
REQ-009 rd_en  input  1  read request, sampled at rising edge.
REQ-010 din  input  DATA_W  write data, sampled with wr_en.
REQ-011 dout  output  DATA_W  registered read data.
REQ-012 full, empty, almost_full, almost_empty  output  1 each  level flags.
REQ-013 wr_ack, wr_err, rd_ack, rd_err  output  1 each  registered one-cycle status pulses.
REQ-014 data_count  output  ADDR_W+1  current occupancy, 0..DEPTH.
REQ-015 state  output  3  registered operation state.

Function
REQ-016 State encoding: IDLE=000, WRITE=001, READ=010, WR_ERROR=011, RD_ERROR=100, WR_RD=101; other codes unreachable.
REQ-017 Classification at each edge uses the sampled wr_en and rd_en and the pre-edge data_count. The state register takes the result at that same edge.
REQ-018 No request: state IDLE; no pointer or count change.
REQ-019 wr_en only, not full: write din to mem[tail]; tail+1; count+1; state WRITE; wr_ack=1.
REQ-020 wr_en only, full: no write; no pointer or count change; state WR_ERROR; wr_err=1.
REQ-021 rd_en only, not empty: dout<=mem[head]; head+1; count-1; state READ; rd_ack=1.
REQ-022 rd_en only, empty: dout holds; no change; state RD_ERROR; rd_err=1.
REQ-023 wr_en and rd_en, not empty: read and write both performed; head+1; tail+1; count unchanged; state WR_RD; wr_ack=1; rd_ack=1.
REQ-024 The rule in REQ-023 also applies when full. The read returns the old mem[head] before the same-edge write to that slot, so no wr_err is raised.
REQ-025 wr_en and rd_en, empty: write only; tail+1; count+1; dout holds; state WRITE; wr_ack=1; rd_err=1.
REQ-026 Ack and error outputs are high for exactly the one cycle after the classifying edge and are 0 otherwise. wr_ack and wr_err are never both 1; rd_ack and rd_err are never both 1.
REQ-027 Read latency: data on dout in the cycle after the rd_en edge, coincident with rd_ack. dout holds its value until the next successful read.
REQ-028 Pointers are ADDR_W bits wide and wrap modulo DEPTH with no special case. data_count is ADDR_W+1 bits and never leaves 0..DEPTH.
REQ-029 Flags are decoded from registered data_count only:
  - full = (count==DEPTH)
  - empty = (count==0)
  - almost_full = (count>=AF_LEVEL)
  - almost_empty = (count<=AE_LEVEL)
REQ-030 Data order is strictly first-in first-out across any interleaving of requests and any number of pointer wraps.

Reset
REQ-031 When reset=1 at an edge, the following values are set:
  - head, tail and data_count = 0
  - state = IDLE
  - dout = 0
  - all ack and err outputs = 0
  - flags: empty=1, almost_empty=1, full=0, almost_full=0 (for legal parameters)
REQ-032 Reset has priority over wr_en and rd_en at the same edge; a request in a reset cycle is discarded without a status pulse.
REQ-033 Memory contents are not cleared by reset. Data written before a reset is unreachable afterwards.
REQ-034 A reset asserted mid-stream (count>0) empties the FIFO in one edge. A read on the first post-reset edge yields RD_ERROR.

Verification (DATA_W=32, ADDR_W=3, AF_LEVEL=7, AE_LEVEL=1)
REQ-035 Fill and overflow:
  - stimulus: reset, then 9 writes of 0x11..0x19
  - required: writes 1-8 give wr_ack with count 1..8; almost_full rises at count 7 and full at count 8
  - required: write 9 gives wr_err, state WR_ERROR, count stays 8
REQ-036 Drain and underflow:
  - stimulus: from full, 9 reads
  - required: dout = 0x11..0x18 each with rd_ack; empty at count 0
  - required: read 9 gives rd_err, state RD_ERROR, dout stays 0x18
REQ-037 Simultaneous requests at the boundaries:
  - stimulus: wr+rd at count 0
  - required: state WRITE, wr_ack=1, rd_err=1, count 1
  - stimulus: wr+rd at count 8
  - required: state WR_RD, old head word returned, count stays 8, no wr_err
REQ-038 Wrap-around:
  - stimulus: 20 alternating write/read pairs plus 12 concurrent wr+rd cycles at count 4
  - required: FIFO order preserved across pointer wraps; count stays 4 during the concurrent phase
REQ-039 Reset mid-operation:
  - stimulus: count 5 with reset asserted together with wr_en
  - required: next cycle count 0, state IDLE, empty=1, no wr_ack
  - stimulus: following read
  - required: rd_err
